// File: rtl/alu_cmd_driver_if.sv
// Command and response channels between a command source and alu_cmd_driver.
// master = command source / response sink; slave = the driver.
interface alu_cmd_driver_if #(
  parameter int unsigned ID_W = 4
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [7:0]      cmd_a;
  logic [7:0]      cmd_b;
  logic            cmd_op;
  logic [ID_W-1:0] cmd_id;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [15:0]     rsp_data;
  logic [ID_W-1:0] rsp_id;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_id, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_id, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Buffers ALU operand commands, drives the add/multiply ALU and returns tagged results.
// Optional result self-check (expected value, o_rsp_err, o_err_cnt) under `ALU_CMD_DRIVER_CHECK_EN.
module alu_cmd_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  alu_cmd_driver_if.slave bus,
  output logic        o_alu_rst,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic        o_alu_sel,
  input  logic [15:0] i_alu_result,
  output logic        o_busy,
  output logic [15:0] o_issued_cnt
`ifdef ALU_CMD_DRIVER_CHECK_EN
  ,
  output logic [15:0] o_err_cnt
`endif
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned WCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  typedef struct packed {
    logic [7:0]      a;
    logic [7:0]      b;
    logic            op;
    logic [ID_W-1:0] id;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  cmd_t            mem [DEPTH];
  cmd_t            head, entry_in;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop, capture;
  logic [WCW-1:0]  wait_cnt;
  logic [ID_W-1:0] pend_id;
  logic [15:0]     rsp_data_q;
  logic [ID_W-1:0] rsp_id_q;

  // Ready is forced low while reset is asserted, not just after the reset edge.
  assign full          = (count == CNT_FULL);
  assign empty         = (count == '0);
  assign bus.cmd_ready = i_reset && !full;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = mem[rd_ptr];
  assign entry_in      = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, id: bus.cmd_id};
  assign capture       = (state_q == WAIT) && (wait_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH:  state_d = WAIT;
      WAIT:    if (wait_cnt == '0) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands stay on the ALU bus from one pop to the next.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_alu_a      <= '0;
      o_alu_b      <= '0;
      o_alu_sel    <= 1'b0;
      pend_id      <= '0;
      o_issued_cnt <= '0;
    end else if (pop) begin
      o_alu_a      <= head.a;
      o_alu_b      <= head.b;
      o_alu_sel    <= head.op;
      pend_id      <= head.id;
      o_issued_cnt <= o_issued_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wait_cnt <= '0;
    end else if (state_q == LAUNCH) begin
      wait_cnt <= WCW'(ALU_LAT - 1);
    end else if ((state_q == WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else if (capture) begin
      rsp_data_q <= i_alu_result;
      rsp_id_q   <= pend_id;
    end
  end

  always_ff @(posedge i_clk) begin
    o_alu_rst <= !i_reset;
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign o_busy        = (state_q != IDLE) || !empty;

`ifdef ALU_CMD_DRIVER_CHECK_EN
  logic [15:0] exp_calc, exp_q;
  logic        rsp_err_q;

  assign exp_calc = head.op ? {7'b0, ({1'b0, head.a} + {1'b0, head.b})}
                            : (16'(head.a) * 16'(head.b));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      exp_q     <= '0;
      rsp_err_q <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      if (pop) exp_q <= exp_calc;
      if (capture) begin
        rsp_err_q <= (i_alu_result != exp_q);
        if ((i_alu_result != exp_q) && (o_err_cnt != '1)) begin
          o_err_cnt <= o_err_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a registered add/multiply ALU model (latency 1).
module tb_alu_cmd_driver;
  localparam int unsigned ID_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_cmd_driver_if #(.ID_W(ID_W)) bus();

  logic        alu_rst, alu_sel, busy;
  logic [7:0]  alu_a, alu_b;
  logic [15:0] alu_result, issued;
  logic        corrupt;
`ifdef ALU_CMD_DRIVER_CHECK_EN
  logic [15:0] err_cnt;
`endif

  alu_cmd_driver #(.DEPTH(4), .ID_W(ID_W), .ALU_LAT(1)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .bus          (bus),
    .o_alu_rst    (alu_rst),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_sel    (alu_sel),
    .i_alu_result (alu_result),
    .o_busy       (busy),
    .o_issued_cnt (issued)
`ifdef ALU_CMD_DRIVER_CHECK_EN
    ,
    .o_err_cnt    (err_cnt)
`endif
  );

  // ALU model: registered result, optional deliberate corruption of 2*3
  always @(posedge clk) begin
    if (alu_rst) alu_result <= '0;
    else if (corrupt && !alu_sel && alu_a == 8'd2 && alu_b == 8'd3) alu_result <= 16'h0010;
    else if (alu_sel) alu_result <= {7'b0, ({1'b0, alu_a} + {1'b0, alu_b})};
    else alu_result <= 16'(alu_a) * 16'(alu_b);
  end

  typedef struct {
    logic [15:0]     data;
    logic [ID_W-1:0] id;
    logic            err;
  } rsp_t;

  rsp_t rsp_q[$];
  int   hs_cnt = 0;

  // Inputs only change at posedge+1, so a negedge sample predicts the handshake.
  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      rsp_q.push_back('{bus.rsp_data, bus.rsp_id, bus.rsp_err});
      hs_cnt++;
    end
  end

  typedef struct {
    logic [7:0]      a;
    logic [7:0]      b;
    logic            op;
    logic [ID_W-1:0] id;
    logic [15:0]     exp;
  } vec_t;

  vec_t vecs[8];
  int   n_err = 0;
  int   n_checks = 0;
  int   exp_issued = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic op,
                      input logic [ID_W-1:0] id);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    bus.cmd_id = id;
    while (n < 200) begin
      if (bus.cmd_ready) begin
        tick();
        acc = 1'b1;
        break;
      end
      tick();
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) check("push_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output rsp_t r);
    int n;
    n = 0;
    while (rsp_q.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    if (rsp_q.size() == 0) begin
      check("rsp_timeout", 32'd0, 32'd1);
      r = '{16'h0, '0, 1'b0};
    end else begin
      r = rsp_q.pop_front();
    end
  endtask

  initial begin
    rsp_t r;
    int   n;
    logic [15:0] d0;
    logic [ID_W-1:0] i0;
    logic e0;
    int   changes;
    int   h0;

    vecs[0] = '{8'd255, 8'd255, 1'b1, 4'd1, 16'h01FE};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 4'd2, 16'hFE01};
    vecs[2] = '{8'd0,   8'd0,   1'b0, 4'd3, 16'h0000};
    vecs[3] = '{8'd0,   8'd255, 1'b1, 4'd4, 16'h00FF};
    vecs[4] = '{8'd16,  8'd16,  1'b0, 4'd6, 16'h0100};
    vecs[5] = '{8'd200, 8'd100, 1'b1, 4'd7, 16'h012C};
    vecs[6] = '{8'd12,  8'd11,  1'b0, 4'd8, 16'h0084};
    vecs[7] = '{8'd128, 8'd2,   1'b0, 4'hF, 16'h0100};

    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = 1'b0;
    bus.cmd_id = '0;
    bus.rsp_ready = 1'b1;
    corrupt = 1'b0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_rst", alu_rst, 1);
    check("rst_alu_ops", {alu_a, alu_b, 7'b0, alu_sel}, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_issued", issued, 0);
`ifdef ALU_CMD_DRIVER_CHECK_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    rst_n = 1'b1;
    tick();
    check("post_rst_alu_rst", alu_rst, 0);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // Single add: LAUNCH operands and ALU_LAT+2 latency
    push(8'd3, 8'd4, 1'b1, 4'd5);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        check("launch_alu_a", alu_a, 3);
        check("launch_alu_b", alu_b, 4);
        check("launch_alu_sel", alu_sel, 1);
      end
    end while (!bus.rsp_valid && n < 20);
    check("latency_cycles", n, 3);
    check("add_data", bus.rsp_data, 16'h0007);
    check("add_id", bus.rsp_id, 5);
    check("add_err", bus.rsp_err, 0);
    wait_rsp(r);
    exp_issued = 1;
    check("add_issued", issued, exp_issued);
    tick();
    check("idle_busy", busy, 0);

    // Table-driven vectors, one at a time
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].id);
      wait_rsp(r);
      exp_issued++;
      check($sformatf("vec%0d_data", i), r.data, vecs[i].exp);
      check($sformatf("vec%0d_id", i), r.id, vecs[i].id);
      check($sformatf("vec%0d_err", i), r.err, 0);
      check($sformatf("vec%0d_issued", i), issued, exp_issued);
    end
    repeat (3) tick();

    // Full FIFO with response backpressure
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(i + 1), 8'd2, 1'b1, ID_W'(i));
    check("full_cmd_ready", bus.cmd_ready, 0);
    check("full_busy", busy, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_id = 4'd5;
    repeat (3) tick();
    check("full_still_blocked", bus.cmd_ready, 0);
    check("full_no_rsp", rsp_q.size(), 0);
    bus.rsp_ready = 1'b1;
    push(8'd6, 8'd2, 1'b1, 4'd5);
    check("full_id5_after_rsp", (hs_cnt > 0) ? 1 : 0, 1);
    n = 0;
    while (rsp_q.size() < 6 && n < 100) begin
      tick();
      n++;
    end
    check("full_rsp_count", rsp_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      wait_rsp(r);
      check($sformatf("full_order_id%0d", i), r.id, i);
      check($sformatf("full_data%0d", i), r.data, i + 3);
    end
    exp_issued += 6;
    check("full_issued", issued, exp_issued);

    // Backpressure stability in RESP
    bus.rsp_ready = 1'b0;
    push(8'd10, 8'd20, 1'b0, 4'd9);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_valid", bus.rsp_valid, 1);
    d0 = bus.rsp_data;
    i0 = bus.rsp_id;
    e0 = bus.rsp_err;
    check("bp_data", d0, 16'd200);
    check("bp_id", i0, 9);
    changes = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.rsp_id !== i0 || bus.rsp_err !== e0)
        changes++;
    end
    check("bp_stable", changes, 0);
    h0 = hs_cnt;
    bus.rsp_ready = 1'b1;
    repeat (6) tick();
    check("bp_one_handshake", hs_cnt - h0, 1);
    wait_rsp(r);
    check("bp_rsp_data", r.data, 16'd200);
    exp_issued++;
    check("bp_issued", issued, exp_issued);

    // Reset while one command is in WAIT and two are queued
    rsp_q.delete();
    push(8'd1, 8'd1, 1'b1, 4'd1);
    push(8'd2, 8'd2, 1'b1, 4'd2);
    push(8'd3, 8'd3, 1'b1, 4'd3);
    check("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    check("midrst_alu_rst", alu_rst, 1);
    check("midrst_busy", busy, 0);
    check("midrst_issued", issued, 0);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 0);
    rst_n = 1'b1;
    tick();
    check("midrst_alu_rst_drop", alu_rst, 0);
    repeat (10) tick();
    check("midrst_no_rsp", rsp_q.size(), 0);
    check("midrst_idle_busy", busy, 0);
    push(8'd7, 8'd6, 1'b0, 4'd12);
    wait_rsp(r);
    check("midrst_new_data", r.data, 16'h002A);
    check("midrst_new_id", r.id, 12);
    check("midrst_new_issued", issued, 1);

`ifdef ALU_CMD_DRIVER_CHECK_EN
    // Result checker: corrupted multiply, then a correct add
    corrupt = 1'b1;
    push(8'd2, 8'd3, 1'b0, 4'd13);
    wait_rsp(r);
    check("chk_bad_data", r.data, 16'h0010);
    check("chk_bad_err", r.err, 1);
    check("chk_err_cnt1", err_cnt, 1);
    push(8'd2, 8'd3, 1'b1, 4'd14);
    wait_rsp(r);
    check("chk_good_data", r.data, 16'h0005);
    check("chk_good_err", r.err, 0);
    check("chk_err_cnt_hold", err_cnt, 1);
    corrupt = 1'b0;
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
